// File: rtl/motion_pkg.sv
// Shared types and constants for the motion sequencer: FSM states, step word layout,
// the FIFO command payload and axis indices.
package motion_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned DIR_BIT  = 31;
  localparam int unsigned MAG_W    = 31;
  localparam int unsigned NUM_AXES = 3;
  localparam int unsigned AXIS_X   = 0;
  localparam int unsigned AXIS_Y   = 1;
  localparam int unsigned AXIS_Z   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_RELEASE
  } state_t;

  typedef logic [WORD_W-1:0] step_word_t;

  typedef struct packed {
    step_word_t        x;
    step_word_t        y;
    step_word_t        z;
    logic [WORD_W-1:0] speed;
  } cmd_t;

  // An axis takes part in a move only when its magnitude is non-zero; direction is ignored.
  function automatic logic step_nz(input step_word_t w);
    return |w[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/motion_sequencer_if.sv
// Command port and per-axis stepper driver bundle of the motion sequencer.
interface motion_sequencer_if;
  import motion_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  step_word_t        cmd_x;
  step_word_t        cmd_y;
  step_word_t        cmd_z;
  logic [WORD_W-1:0] cmd_speed;

  step_word_t        step_x;
  step_word_t        step_y;
  step_word_t        step_z;
  logic [WORD_W-1:0] speed;
  logic              start_x;
  logic              start_y;
  logic              start_z;
  logic              driving_x;
  logic              driving_y;
  logic              driving_z;
  logic [WORD_W-1:0] remain_x;
  logic [WORD_W-1:0] remain_y;
  logic [WORD_W-1:0] remain_z;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_z, cmd_speed,
    input  driving_x, driving_y, driving_z, remain_x, remain_y, remain_z,
    output cmd_ready, step_x, step_y, step_z, speed, start_x, start_y, start_z
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_z, cmd_speed,
    output driving_x, driving_y, driving_z, remain_x, remain_y, remain_z,
    input  cmd_ready, step_x, step_y, step_z, speed, start_x, start_y, start_z
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with occupancy output; flush empties it in one cycle.
module cmd_fifo
  import motion_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  cmd_t                   din,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (level != LVL_W'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/motion_sequencer.sv
// Move scheduler for the X/Y/Z stepper drivers: queue, launch, wait, release.
// Optional move watchdog enabled by defining MOTION_SEQ_WATCHDOG_EN.
module motion_sequencer
  import motion_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] WDOG_CYCLES = 32'd100_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  motion_sequencer_if.slave      bus,
  input  logic                   abort,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   move_done,
  output logic [NUM_AXES-1:0]    stall,
  output logic                   fault
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_t              state_q, state_d;
  cmd_t                fifo_din, head;
  logic                ready, push, pop, abort_eff, wdog_trip;
  logic [NUM_AXES-1:0] mask_q, mask_d, start_q, start_d, stall_d, rem_nz, drv;
  step_word_t          step_x_q, step_y_q, step_z_q;
  step_word_t          step_x_d, step_y_d, step_z_d;
  logic [WORD_W-1:0]   speed_q, speed_d;
  logic                busy_d, move_done_d;
  logic                unused_sign;

  assign fifo_din = {bus.cmd_x, bus.cmd_y, bus.cmd_z, bus.cmd_speed};

  // Ready depends only on occupancy (and the sticky fault), never on a same-cycle pop.
  assign ready     = (level != LVL_W'(DEPTH)) && !fault;
  assign abort_eff = abort || wdog_trip;
  assign push      = bus.cmd_valid && ready && !abort_eff;
  assign pop       = (state_q == S_IDLE) && (level != '0) && !fault && !abort_eff;

  assign rem_nz[AXIS_X] = |bus.remain_x[MAG_W-1:0];
  assign rem_nz[AXIS_Y] = |bus.remain_y[MAG_W-1:0];
  assign rem_nz[AXIS_Z] = |bus.remain_z[MAG_W-1:0];
  assign drv[AXIS_X]    = bus.driving_x;
  assign drv[AXIS_Y]    = bus.driving_y;
  assign drv[AXIS_Z]    = bus.driving_z;
  assign unused_sign    = bus.remain_x[DIR_BIT] ^ bus.remain_y[DIR_BIT] ^ bus.remain_z[DIR_BIT];

  assign bus.cmd_ready = ready;
  assign bus.step_x    = step_x_q;
  assign bus.step_y    = step_y_q;
  assign bus.step_z    = step_z_q;
  assign bus.speed     = speed_q;
  assign bus.start_x   = start_q[AXIS_X];
  assign bus.start_y   = start_q[AXIS_Y];
  assign bus.start_z   = start_q[AXIS_Z];

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (abort_eff),
    .din   (fifo_din),
    .head  (head),
    .level (level)
  );

  // State register together with the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      start_q   <= '0;
      step_x_q  <= '0;
      step_y_q  <= '0;
      step_z_q  <= '0;
      speed_q   <= '0;
      busy      <= 1'b0;
      move_done <= 1'b0;
      stall     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      start_q   <= start_d;
      step_x_q  <= step_x_d;
      step_y_q  <= step_y_d;
      step_z_q  <= step_z_d;
      speed_q   <= speed_d;
      busy      <= busy_d;
      move_done <= move_done_d;
      stall     <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_eff) begin
      state_d = S_RELEASE;
    end else begin
      case (state_q)
        S_IDLE:    if (pop) state_d = S_LOAD;
        S_LOAD:    state_d = (mask_q == '0) ? S_RELEASE : S_ISSUE;
        S_ISSUE:   state_d = S_SETTLE;
        S_SETTLE:  state_d = S_WAIT;
        S_WAIT:    if ((mask_q & drv) == '0) state_d = S_RELEASE;
        S_RELEASE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mask_d      = mask_q;
    start_d     = start_q;
    step_x_d    = step_x_q;
    step_y_d    = step_y_q;
    step_z_d    = step_z_q;
    speed_d     = speed_q;
    move_done_d = 1'b0;
    stall_d     = '0;
    busy_d      = (state_d != S_IDLE);
    if (abort_eff) begin
      start_d = '0;
      // Only a move whose starts were already raised can report a stall.
      if (state_q == S_SETTLE || state_q == S_WAIT) stall_d = mask_q & rem_nz;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            step_x_d       = head.x;
            step_y_d       = head.y;
            step_z_d       = head.z;
            speed_d        = (head.speed == '0) ? WORD_W'(1) : head.speed;
            mask_d[AXIS_X] = step_nz(head.x);
            mask_d[AXIS_Y] = step_nz(head.y);
            mask_d[AXIS_Z] = step_nz(head.z);
          end
        end
        S_LOAD:  move_done_d = (mask_q == '0);
        S_ISSUE: start_d = mask_q;
        S_WAIT: begin
          if (state_d == S_RELEASE) begin
            start_d     = '0;
            stall_d     = mask_q & rem_nz;
            move_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MOTION_SEQ_WATCHDOG_EN
  logic [31:0] wdog_q;
  logic        fault_q;

  // Trips on the WAIT cycle whose increment would reach the limit.
  assign wdog_trip = (state_q == S_WAIT) && ((wdog_q + 32'd1) >= WDOG_CYCLES);
  assign fault     = fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)     wdog_q <= '0;
      else if (state_q == S_WAIT) wdog_q <= wdog_q + 32'd1;
      if (wdog_trip) fault_q <= 1'b1;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wdog_trip   = 1'b0;
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_motion_sequencer.sv
// Scoreboard bench for motion_sequencer with behavioural stepper driver models.
module tb_motion_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       busy;
  logic [2:0] level;
  logic       move_done;
  logic [2:0] stall;
  logic       fault;
  logic [2:0] st;
  logic [2:0] drv;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hold;
  logic [2:0]  refuse;
  logic [2:0]  stuck;
  logic [31:0] end_rem [3];

  typedef struct {
    logic [31:0] x, y, z, spd;
    logic [2:0]  mask, stall;
  } exp_t;
  exp_t exp_q[$];

  motion_sequencer_if bus ();

  motion_sequencer #(.DEPTH(4), .WDOG_CYCLES(32'd50)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .abort     (abort),
    .busy      (busy),
    .level     (level),
    .move_done (move_done),
    .stall     (stall),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  assign st            = {bus.start_z, bus.start_y, bus.start_x};
  assign bus.driving_x = drv[0];
  assign bus.driving_y = drv[1];
  assign bus.driving_z = drv[2];
  assign bus.remain_x  = drv[0] ? 32'h100 : end_rem[0];
  assign bus.remain_y  = drv[1] ? 32'h100 : end_rem[1];
  assign bus.remain_z  = drv[2] ? 32'h100 : end_rem[2];

  // Driver model: arms on a rising start, drives for 'hold' cycles unless refused or stuck.
  for (genvar a = 0; a < 3; a++) begin : g_drv
    logic d, armed;
    int   cnt;
    always @(posedge clk) begin
      if (rst || !st[a]) begin
        d     <= 1'b0;
        armed <= 1'b0;
      end else if (!armed) begin
        armed <= 1'b1;
        if (!refuse[a]) begin
          d   <= 1'b1;
          cnt <= hold;
        end
      end else if (d && !stuck[a]) begin
        if (cnt <= 1) d <= 1'b0;
        else cnt <= cnt - 1;
      end
    end
    assign drv[a] = d;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [31:0] x, y, z, spd);
    exp_t e;
    int   n = 0;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_z     = z;
    bus.cmd_speed = spd;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      check("push_timeout", 64'(bus.cmd_ready), 64'd1);
    end else begin
      e.x     = x;
      e.y     = y;
      e.z     = z;
      e.spd   = (spd == 0) ? 32'd1 : spd;
      e.mask  = {|z[30:0], |y[30:0], |x[30:0]};
      e.stall = e.mask & {|end_rem[2][30:0], |end_rem[1][30:0], |end_rem[0][30:0]};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || level != 0 || exp_q.size() != 0) && n < budget);
    check("idle_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: retire scoreboard entries on move_done and check the pulse properties.
  logic [2:0] start_seen = '0;
  logic       prev_md = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      start_seen = '0;
      prev_md    = 1'b0;
    end else begin
      start_seen = start_seen | st;
      if (move_done) begin
        exp_t e;
        check("done_pulse_width", 64'(prev_md), 64'd0);
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("step_x", bus.step_x, e.x);
          check("step_y", bus.step_y, e.y);
          check("step_z", bus.step_z, e.z);
          check("speed", bus.speed, e.spd);
          check("start_mask", start_seen, e.mask);
          check("release_starts_low", st, 3'b000);
          check("stall", stall, e.stall);
        end
      end else if (prev_md) begin
        check("stall_pulse_width", stall, 3'b000);
      end
      if (!busy) start_seen = '0;
      prev_md = move_done;
      if (level == 3'd4) check("ready_when_full", 64'(bus.cmd_ready), 64'd0);
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst           = 1'b1;
    abort         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_z     = '0;
    bus.cmd_speed = '0;
    hold          = 3;
    refuse        = '0;
    stuck         = '0;
    for (int i = 0; i < 3; i++) end_rem[i] = '0;

    apply_reset();
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_start", st, 0);
    check("rst_done", move_done, 0);
    check("rst_stall", stall, 0);
    check("rst_fault", fault, 0);
    check("rst_speed", bus.speed, 0);
    check("rst_step_x", bus.step_x, 0);

    // Basic move with cycle-exact launch timing
    push_cmd(32'd100, 32'd0, 32'h8000_0010, 32'd5);
    @(negedge clk);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_level", level, 1);
    @(negedge clk);
    check("t1_load_busy", busy, 1);
    check("t1_load_level", level, 0);
    check("t1_load_step_z", bus.step_z, 32'h8000_0010);
    @(negedge clk);
    check("t1_issue_start", st, 3'b000);
    @(negedge clk);
    check("t1_settle_start", st, 3'b101);
    wait_idle(200);

    // Back-to-back commands with busy drivers; overfill blocks until space frees
    hold = 20;
    push_cmd(32'd1, 32'd2, 32'd3, 32'd7);
    push_cmd(32'h8000_0005, 32'd0, 32'd9, 32'd0);
    push_cmd(32'd0, 32'd0, 32'd4, 32'd3);
    push_cmd(32'd11, 32'd12, 32'd13, 32'd2);
    push_cmd(32'h8000_0020, 32'h8000_0021, 32'd0, 32'd6);
    check("full_level", level, 4);
    check("full_ready", bus.cmd_ready, 0);
    push_cmd(32'd7, 32'd0, 32'd0, 32'd1);
    wait_idle(2000);

    // All-zero magnitudes: retire without any start
    hold = 3;
    push_cmd(32'd0, 32'd0, 32'h8000_0000, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check("zero_load_done", move_done, 0);
    @(negedge clk);
    check("zero_done", move_done, 1);
    check("zero_start", st, 3'b000);
    wait_idle(50);

    // Z endstop leaves steps remaining; refused Y never drives
    end_rem[2] = 32'h0000_0007;
    push_cmd(32'd10, 32'd0, 32'd50, 32'd2);
    wait_idle(100);
    end_rem[2] = '0;
    end_rem[1] = 32'd5;
    refuse[1]  = 1'b1;
    push_cmd(32'd0, 32'd20, 32'd0, 32'd3);
    wait_idle(100);
    end_rem[1] = '0;
    refuse     = '0;

    // Abort mid-WAIT with two queued; simultaneous push is dropped
    hold = 40;
    push_cmd(32'd30, 32'd0, 32'd0, 32'd4);
    push_cmd(32'd31, 32'd0, 32'd0, 32'd4);
    push_cmd(32'd32, 32'd0, 32'd0, 32'd4);
    repeat (8) @(negedge clk);
    check("abort_pre_level", level, 2);
    check("abort_pre_start", st, 3'b001);
    abort         = 1'b1;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    abort         = 1'b0;
    bus.cmd_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_start", st, 3'b000);
    check("abort_level", level, 0);
    check("abort_done", move_done, 0);
    check("abort_busy", busy, 1);
    check("abort_stall", stall, 3'b001);
    @(negedge clk);
    check("abort_busy_drop", busy, 0);
    check("abort_done2", move_done, 0);
    check("abort_level2", level, 0);

    // Recovery after abort
    hold = 2;
    push_cmd(32'd5, 32'd6, 32'd7, 32'd9);
    wait_idle(100);

`ifdef MOTION_SEQ_WATCHDOG_EN
    stuck[0] = 1'b1;
    hold     = 5;
    push_cmd(32'd40, 32'd0, 32'd0, 32'd4);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (st == 3'b000 && n < 20);
    check("wd_start_seen", st, 3'b001);
    repeat (50) @(negedge clk);
    check("wd_pre_fault", fault, 0);
    @(negedge clk);
    check("wd_fault", fault, 1);
    check("wd_ready", bus.cmd_ready, 0);
    check("wd_no_done", move_done, 0);
    exp_q.delete();
    stuck = '0;
    repeat (5) @(negedge clk);
    check("wd_fault_held", fault, 1);
    check("wd_ready_held", bus.cmd_ready, 0);
    check("wd_idle", busy, 0);
    apply_reset();
    check("wd_rst_fault", fault, 0);
    check("wd_rst_ready", bus.cmd_ready, 1);
`else
    n = 0;
    check("fault_tied", fault, 0);
    check("ready_end", bus.cmd_ready, 1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/motion_sequencer.md
# motion_sequencer

Command scheduler for the three stepper axis drivers (X, Y, Z). Buffers move commands in a small FIFO, launches each move on all axes with a shared speed, waits until every launched axis finishes, and tears down the start level so drivers re-arm. Sits between the host/G-code command path and the per-axis stepper drivers; reports endstop stalls and queue state.

## Interface
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- WDOG_CYCLES, 32'd100_000_000: move watchdog limit; used only with MOTION_SEQ_WATCHDOG_EN.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full; a push occurs when valid&ready.
- cmd_x, cmd_y, cmd_z  in  32  step word: bit31 = direction, [30:0] = magnitude.
- cmd_speed  in  32  half-period in clk cycles.
- abort  in  1  flush queue and stop current move.
- step_x, step_y, step_z  out  32  step word to each driver.
- speed  out  32  shared speed to drivers.
- start_x, start_y, start_z  out  1  per-axis start_driving level.
- driving_x, driving_y, driving_z  in  1  driver stepper_driving.
- remain_x, remain_y, remain_z  in  32  driver stepper_step_out.
- busy  out  1  state ≠ IDLE.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- move_done  out  1  one-cycle pulse per retired move.
- stall  out  3  one-cycle pulse per axis {z,y,x}: axis ended with remain[30:0]≠0.
- fault  out  1  sticky watchdog fault (0 without macro).

## Operation
- FIFO stores {x,y,z,speed}; all outputs registered.
- States: IDLE, LOAD, ISSUE, SETTLE, WAIT, RELEASE.
- IDLE: if level≠0 → LOAD (pop head).
- LOAD: drive step_*, speed from head; speed 0 is clamped to 1. active mask = axes with magnitude ≠ 0. Mask all-zero → RELEASE directly (no starts).
- ISSUE: start_* ← mask bits; → SETTLE.
- SETTLE: one cycle for drivers to register start; → WAIT.
- WAIT: stay while any (mask & driving) bit is high; else → RELEASE. An axis refused by its endstop never asserts driving and counts as finished.
- RELEASE: all start_* ← 0 for exactly one cycle (clears driver arm flag); sample remain_* for masked axes → stall pulses; move_done pulse; → IDLE.
- abort (any state): start_* ← 0, FIFO emptied, → RELEASE with move_done suppressed; stall still reported for a move in progress.
- Push during abort cycle is dropped; push and pop in same cycle keep level unchanged.
- Reset: all outputs 0, cmd_ready 1, level 0, state IDLE, fault 0.

## Timing
- Command accepted with empty FIFO and IDLE: pop at t+1 (IDLE→LOAD), start_* high at t+3, earliest WAIT check t+5.
- Minimum move occupancy: LOAD, ISSUE, SETTLE, WAIT, RELEASE = 5 cycles; back-to-back moves separated by one IDLE cycle.
- cmd_ready combinational from level only; full → 0 even if pop this cycle.
- step_*/speed stable from LOAD through RELEASE.

## Configuration
- MOTION_SEQ_WATCHDOG_EN defined: 32-bit counter clears in ISSUE, increments in WAIT; reaching WDOG_CYCLES acts as abort and sets fault, held until rst. While fault=1, cmd_ready=0 and no pops.
- Undefined: no counter, fault tied 0, WAIT unbounded.

## Structure
- motion_pkg: state enum, DIR_BIT=31, MAG_W=31, step word typedef, axis index constants X=0/Y=1/Z=2.
- Sub-module cmd_fifo (synchronous, DEPTH×128 bits, level output, pointer wrap at DEPTH).

## Test plan
- Push x=100, y=0, z=0x8000_0010, speed=5 → start_x, start_z high, start_y low; drivers finish → one RELEASE cycle with starts low, move_done=1, stall=0.
- Push 5 commands with drivers held busy, DEPTH=4 → 4th push after first pop accepted, cmd_ready=0 when level=4, no loss, moves retire in order.
- All-zero command → no start pulses, move_done within 3 cycles of pop.
- Z endstop: remain_z=0x0000_0007 when driving_z falls → stall=3'b100 in RELEASE.
- abort mid-WAIT with level=2 → starts low next cycle, level=0, no move_done, busy drops after RELEASE.
- Watchdog (macro on, WDOG_CYCLES=50): driving_x stuck high → fault=1 at cycle 50 of WAIT, cmd_ready=0 until rst.
